// File: rtl/stack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : stack_pkg                                                        |
// | Purpose : Shared definitions for the stack controller: CPU op codes,       |
// |           memory strobe encodings, error codes, internal op kinds and the  |
// |           sequencer state encoding.                                        |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package stack_pkg;

   // Encodings of the op_code bus as issued by the CPU core.
   localparam logic [1:0] OPC_NOP   = 2'd0;
   localparam logic [1:0] OPC_PUSH  = 2'd1;
   localparam logic [1:0] OPC_POP   = 2'd2;
   localparam logic [1:0] OPC_STORE = 2'd3;

   // read_or_write strobe encodings understood by the stack memory.
   localparam logic [3:0] RW_NONE = 4'h0;
   localparam logic [3:0] RW_PUSH = 4'h1;   // write write_data at esp
   localparam logic [3:0] RW_ADDR = 4'h8;   // write write_data at stack_addr

   // Word size in bytes; ESP moves by this amount per push/pop.
   localparam logic [31:0] WORD_BYTES = 32'd4;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_OVF  = 2'd1,
      ERR_UNF  = 2'd2,
      ERR_ADDR = 2'd3
   } err_code_t;

   // Internal op kind: op_code and op_load folded into one decoded value.
   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_PUSH  = 3'd1,
      OP_POP   = 3'd2,
      OP_STORE = 3'd3,
      OP_LOAD  = 3'd4
   } op_kind_t;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_CHECK    = 4'd1,
      ST_PUSH_DEC = 4'd2,
      ST_PUSH_WR  = 4'd3,
      ST_POP_RD   = 4'd4,
      ST_POP_INC  = 4'd5,
      ST_ST_WR    = 4'd6,
      ST_LD_RD    = 4'd7,
      ST_DONE     = 4'd8
   } state_t;

   // op_load only has meaning alongside the NOP code; with any other code
   // it is ignored so a stray op_load cannot turn a PUSH into a LOAD.
   function automatic op_kind_t decode_op(input logic [1:0] code, input logic load);
      op_kind_t kind;
      kind = OP_NOP;
      case (code)
         OPC_NOP:   kind = load ? OP_LOAD : OP_NOP;
         OPC_PUSH:  kind = OP_PUSH;
         OPC_POP:   kind = OP_POP;
         OPC_STORE: kind = OP_STORE;
         default:   kind = OP_NOP;
      endcase
      return kind;
   endfunction

endpackage : stack_pkg
`default_nettype wire

// File: rtl/stack_bounds_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : stack_bounds_check                                               |
// | Purpose : Combinational legality check for a latched stack op. Flags       |
// |           push into a full stack, pop from an empty stack and misaligned / |
// |           out-of-range LOAD/STORE addresses.                               |
// | Ports   : op        in  op_kind_t  decoded operation                       |
// |           esp       in  32         current stack pointer                   |
// |           addr      in  32         LOAD/STORE byte address                 |
// |           err       out 1          op is illegal                           |
// |           err_code  out 2          reason (err_code_t), ERR_NONE if legal  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module stack_bounds_check
   import stack_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 512,
   parameter logic [31:0] STACK_TOP = 32'h0000_01FC,
   parameter logic [31:0] STACK_LIM = 32'h0000_0000
)(
   input  op_kind_t    op,
   input  logic [31:0] esp,
   input  logic [31:0] addr,
   output logic        err,
   output logic [1:0]  err_code
);

   // Highest byte address at which a whole word still fits in memory.
   localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 4);

   logic addr_bad;

   assign addr_bad = (addr[1:0] != 2'b00) || (addr > ADDR_MAX);

   always_comb begin
      err      = 1'b0;
      err_code = ERR_NONE;
      case (op)
         OP_PUSH: begin
            if (esp == STACK_LIM) begin
               err      = 1'b1;
               err_code = ERR_OVF;
            end
         end
         OP_POP: begin
            if (esp == STACK_TOP) begin
               err      = 1'b1;
               err_code = ERR_UNF;
            end
         end
         OP_LOAD, OP_STORE: begin
            if (addr_bad) begin
               err      = 1'b1;
               err_code = ERR_ADDR;
            end
         end
         default: begin
            err      = 1'b0;
            err_code = ERR_NONE;
         end
      endcase
   end

endmodule : stack_bounds_check
`default_nettype wire

// File: rtl/stack_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : stack_controller                                                 |
// | Purpose : Sequencer between the CPU core and the stack memory. Accepts     |
// |           PUSH/POP/LOAD/STORE over valid/ready, owns the full-descending   |
// |           ESP, drives the memory strobes and returns read data with a      |
// |           one-cycle done pulse. Illegal ops raise a sticky error.          |
// | Ports   : clock, reset(async, active-low)                                  |
// |           op_valid/op_ready/op_code/op_load/op_data/op_addr  CPU request   |
// |           done, rd_data                                      CPU response  |
// |           err, err_code                                      sticky error  |
// |           esp, read_or_write, write_data, stack_addr         to memory     |
// |           stack_esp, stack_addr_access                       from memory   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module stack_controller
   import stack_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 512,
   parameter logic [31:0] STACK_TOP = 32'h0000_01FC,
   parameter logic [31:0] STACK_LIM = 32'h0000_0000
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [1:0]  op_code,
   input  logic        op_load,
   input  logic [31:0] op_data,
   input  logic [31:0] op_addr,
   output logic        done,
   output logic [31:0] rd_data,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [31:0] esp,
   output logic [3:0]  read_or_write,
   output logic [31:0] write_data,
   output logic [31:0] stack_addr,
   input  logic [31:0] stack_esp,
   input  logic [31:0] stack_addr_access
);

   state_t      state, state_nx;
   op_kind_t    op_q, op_nx;
   logic [31:0] data_q, data_nx;
   logic [31:0] addr_q, addr_nx;

   // Next values of the registered outputs.
   logic        ready_nx;
   logic        done_nx;
   logic [31:0] rd_nx;
   logic        err_nx;
   logic [1:0]  ec_nx;
   logic [31:0] esp_nx;
   logic [3:0]  rw_nx;
   logic [31:0] wdata_nx;
   logic [31:0] saddr_nx;

   op_kind_t    req_kind;
   logic        chk_err;
   logic [1:0]  chk_code;

   assign req_kind = decode_op(op_code, op_load);

   stack_bounds_check #(
      .MEM_BYTES (MEM_BYTES),
      .STACK_TOP (STACK_TOP),
      .STACK_LIM (STACK_LIM)
   ) u_bounds (
      .op       (op_q),
      .esp      (esp),
      .addr     (addr_q),
      .err      (chk_err),
      .err_code (chk_code)
   );

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state and next-output logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      op_nx    = op_q;
      data_nx  = data_q;
      addr_nx  = addr_q;
      rd_nx    = rd_data;
      err_nx   = err;
      ec_nx    = err_code;
      esp_nx   = esp;
      wdata_nx = write_data;
      saddr_nx = stack_addr;

      case (state)
         ST_IDLE: begin
            // A NOP is consumed here without leaving IDLE, so it never
            // produces a done pulse and op_ready stays high.
            if (op_valid && op_ready && (req_kind != OP_NOP)) begin
               op_nx    = req_kind;
               data_nx  = op_data;
               addr_nx  = op_addr;
               state_nx = ST_CHECK;
            end
         end

         ST_CHECK: begin
            if (chk_err) begin
               // Only the first error is reported; later ones just keep err set.
               err_nx = 1'b1;
               if (err_code == ERR_NONE) begin
                  ec_nx = chk_code;
               end
               state_nx = ST_DONE;
            end else begin
               case (op_q)
                  OP_PUSH:  state_nx = ST_PUSH_DEC;
                  OP_POP:   state_nx = ST_POP_RD;
                  OP_STORE: begin
                     saddr_nx = addr_q;
                     wdata_nx = data_q;
                     state_nx = ST_ST_WR;
                  end
                  OP_LOAD: begin
                     saddr_nx = addr_q;
                     state_nx = ST_LD_RD;
                  end
                  default:  state_nx = ST_DONE;
               endcase
            end
         end

         ST_PUSH_DEC: begin
            // Full-descending: decrement first so PUSH_WR writes at the new ESP.
            esp_nx   = esp - WORD_BYTES;
            wdata_nx = data_q;
            state_nx = ST_PUSH_WR;
         end

         ST_PUSH_WR: state_nx = ST_DONE;

         ST_POP_RD: begin
            rd_nx    = stack_esp;
            state_nx = ST_POP_INC;
         end

         ST_POP_INC: begin
            esp_nx   = esp + WORD_BYTES;
            state_nx = ST_DONE;
         end

         ST_ST_WR: state_nx = ST_DONE;

         ST_LD_RD: begin
            rd_nx    = stack_addr_access;
            state_nx = ST_DONE;
         end

         ST_DONE: state_nx = ST_IDLE;

         default: state_nx = ST_IDLE;
      endcase

      // Outputs are registered, so they are derived from the state being
      // entered; this makes each strobe coincide with its state.
      ready_nx = (state_nx == ST_IDLE);
      done_nx  = (state_nx == ST_DONE);
      if (state_nx == ST_PUSH_WR) begin
         rw_nx = RW_PUSH;
      end else if (state_nx == ST_ST_WR) begin
         rw_nx = RW_ADDR;
      end else begin
         rw_nx = RW_NONE;
      end
   end

   // ---------------------------------------------------------------------
   // Datapath and output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_q          <= OP_NOP;
         data_q        <= 32'h0;
         addr_q        <= 32'h0;
         op_ready      <= 1'b1;
         done          <= 1'b0;
         rd_data       <= 32'h0;
         err           <= 1'b0;
         err_code      <= ERR_NONE;
         esp           <= STACK_TOP;
         read_or_write <= RW_NONE;
         write_data    <= 32'h0;
         stack_addr    <= 32'h0;
      end else begin
         op_q          <= op_nx;
         data_q        <= data_nx;
         addr_q        <= addr_nx;
         op_ready      <= ready_nx;
         done          <= done_nx;
         rd_data       <= rd_nx;
         err           <= err_nx;
         err_code      <= ec_nx;
         esp           <= esp_nx;
         read_or_write <= rw_nx;
         write_data    <= wdata_nx;
         stack_addr    <= saddr_nx;
      end
   end

endmodule : stack_controller
`default_nettype wire
